dense_stream_mac: RTL and testbench

Streaming, parametrised fully-connected layer engine for the manual inference datapath. It consumes one signed fixed-point activation per cycle over a valid/ready input stream and runs N_OUT multiply-accumulates in parallel, one per output neuron. Weights and biases are compile-time parameter arrays in the same Q(WIDTH-NFRAC).NFRAC format as the per-layer weight packages. At frame end it adds the bias, saturates the result, and presents all N_OUT results as one output beat to the next layer.

---
 rtl/dense_stream_pkg.sv | 30 +++
 rtl/dense_stream_lane.sv | 42 ++++
 rtl/dense_stream_mac.sv | 85 ++++++++
 tb/tb_dense_stream_mac.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_stream_pkg.sv
// Shared types and arithmetic helpers for the dense_stream_mac layer engine.
// DENSE_STREAM_RELU_EN (when defined) clamps every lane result at zero.
package dense_stream_pkg;

    typedef enum logic [1:0] {ACCUM, FIN, OUT} state_t;

`ifdef DENSE_STREAM_RELU_EN
    localparam bit RELU_ON = 1'b1;
`else
    localparam bit RELU_ON = 1'b0;
`endif

    // Full product width plus enough headroom for N_IN products, so the sum cannot wrap.
    function automatic int acc_width(input int width, input int n_in);
        return 2 * width + $clog2(n_in);
    endfunction

    // Arithmetic shift (floor) back to the data format, then clamp to the signed WIDTH range.
    function automatic logic signed [127:0] sat_trunc(input logic signed [127:0] acc,
                                                      input int nfrac, input int width);
        logic signed [127:0] sh, hi, lo;
        sh = acc >>> nfrac;
        hi = (128'sd1 <<< (width - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (width - 1));
        if (sh > hi)      return hi;
        else if (sh < lo) return lo;
        else              return sh;
    endfunction

endpackage

// File: rtl/dense_stream_lane.sv
// One MAC lane: accumulator with bias reload, plus combinational requantise and optional ReLU.
module dense_stream_lane
    import dense_stream_pkg::*;
#(
    parameter int               N_IN  = 32,
    parameter int               WIDTH = 24,
    parameter int               NFRAC = 12,
    parameter logic [WIDTH-1:0] BIAS  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    acc_en,
    input  logic                    reload,
    input  logic signed [WIDTH-1:0] data,
    input  logic signed [WIDTH-1:0] weight,
    output logic        [WIDTH-1:0] res
);
    localparam int ACC_W = acc_width(WIDTH, N_IN);

    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   bias_al;
    logic signed [2*WIDTH-1:0] prod;
    logic        [WIDTH-1:0]   q;

    // Bias lives in the product domain (2*NFRAC fractional bits).
    assign bias_al = ACC_W'(signed'(BIAS)) <<< NFRAC;
    assign prod    = data * weight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         acc <= bias_al;
        else if (reload) acc <= bias_al;
        else if (acc_en) acc <= acc + ACC_W'(prod);
    end

    assign q = WIDTH'(sat_trunc(128'(acc), NFRAC, WIDTH));

    always_comb begin
        res = q;
        if (RELU_ON && q[WIDTH-1]) res = '0;
    end

endmodule

// File: rtl/dense_stream_mac.sv
// Streaming fully-connected layer: N_OUT parallel MAC lanes, count-governed frames, one output beat.
// Build option: DENSE_STREAM_RELU_EN clamps negative lane results to zero.
module dense_stream_mac
    import dense_stream_pkg::*;
#(
    parameter int                                      N_IN    = 32,
    parameter int                                      N_OUT   = 5,
    parameter int                                      WIDTH   = 24,
    parameter int                                      NFRAC   = 12,
    parameter logic [N_IN-1:0][N_OUT-1:0][WIDTH-1:0]   WEIGHTS = '0,
    parameter logic [N_OUT-1:0][WIDTH-1:0]             BIAS    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic                   frame_err
);
    localparam int             IW       = $clog2(N_IN);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N_IN - 1);

    state_t                        state;
    logic [IW-1:0]                 idx;
    logic                          accept;
    logic                          reload;
    logic [N_OUT-1:0][WIDTH-1:0]   res;

    assign in_ready = (state == ACCUM) && !rst;
    assign accept   = in_valid && in_ready;
    assign reload   = (state == OUT) && out_ready;

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        dense_stream_lane #(
            .N_IN  (N_IN),
            .WIDTH (WIDTH),
            .NFRAC (NFRAC),
            .BIAS  (BIAS[j])
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .acc_en (accept),
            .reload (reload),
            .data   (in_data),
            .weight (WEIGHTS[idx][j]),
            .res    (res[j])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                ACCUM: if (accept) begin
                    // in_last is only checked; the beat count alone ends the frame.
                    frame_err <= in_last ^ (idx == LAST_IDX);
                    idx       <= idx + 1'b1;
                    if (idx == LAST_IDX) state <= FIN;
                end
                FIN: begin
                    out_data  <= res;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    idx       <= '0;
                    state     <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_stream_mac.sv
// Randomised self-checking bench for dense_stream_mac against a plain-arithmetic layer model.
module tb_dense_stream_mac;
    localparam int N_IN  = 32;
    localparam int N_OUT = 5;
    localparam int WIDTH = 24;
    localparam int NFRAC = 12;
    localparam longint SCALE = longint'(1) << NFRAC;
`ifdef DENSE_STREAM_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    // Lane 0/4: 1.0, lane 1: 0.5, lane 2: -1.0, lane 3: index-dependent fractions.
    function automatic logic [N_IN-1:0][N_OUT-1:0][WIDTH-1:0] gen_w();
        logic [N_IN-1:0][N_OUT-1:0][WIDTH-1:0] w;
        for (int i = 0; i < N_IN; i++) begin
            w[i][0] = 24'h001000;
            w[i][1] = 24'h000800;
            w[i][2] = 24'hFFF000;
            w[i][3] = WIDTH'((((i * 37 + 11) % 97) - 48) * 73);
            w[i][4] = 24'h001000;
        end
        return w;
    endfunction

    localparam logic [N_IN-1:0][N_OUT-1:0][WIDTH-1:0] W_P = gen_w();
    localparam logic [N_OUT-1:0][WIDTH-1:0] B_P =
        {24'h000372, 24'h000A55, 24'h000000, 24'h000000, 24'hFFFF01};

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data = '0;
    logic                   in_last = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic                   frame_err;

    dense_stream_mac #(
        .N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .NFRAC(NFRAC),
        .WEIGHTS(W_P), .BIAS(B_P)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int err_cnt  = 0;
    longint xs [N_IN];

    always @(negedge clk) if (frame_err === 1'b1) err_cnt++;

    function automatic longint sx(input logic [WIDTH-1:0] v);
        return longint'($signed(v));
    endfunction

    // Reference: exact real-valued dot product + bias, floored to NFRAC, clamped, optional ReLU.
    function automatic logic [WIDTH-1:0] model(input int j);
        longint acc, q, hi, lo;
        acc = sx(B_P[j]) * SCALE;
        for (int i = 0; i < N_IN; i++) acc += xs[i] * sx(W_P[i][j]);
        if (acc >= 0) q = acc / SCALE;
        else          q = -((-acc + SCALE - 1) / SCALE);
        hi = (longint'(1) << (WIDTH - 1)) - 1;
        lo = -(longint'(1) << (WIDTH - 1));
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        if (RELU && q < 0) q = 0;
        return WIDTH'(q);
    endfunction

    task automatic send_beats(input int first, input int n, input int last_pos, input bit gaps);
        for (int i = first; i < first + n; i++) begin
            if (gaps) while ($urandom_range(3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = WIDTH'(xs[i]);
            in_last  = (i == last_pos);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(output logic [N_OUT*WIDTH-1:0] d, output bit to, output int lat);
        to = 1'b1; lat = 0; d = '0;
        for (int c = 0; c < 100; c++) begin
            if (out_valid === 1'b1) begin
                to = 1'b0; d = out_data;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL reset_out_data got %h exp 0", out_data); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b exp 0", frame_err); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got %b exp 1", in_ready); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_unity();
        logic [N_OUT*WIDTH-1:0] d; bit to; int lat;
        for (int i = 0; i < N_IN; i++) xs[i] = 64'h1000;
        err_cnt = 0;
        send_beats(0, N_IN, N_IN - 1, 1'b0);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL unity_fin_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL unity_fin_ready got %b exp 0", in_ready); else n_pass++;
        wait_out(d, to, lat);
        n_checks++; if (to || lat != 1) $display("FAIL unity_latency got %0d (timeout %0d) exp 1", lat, to); else n_pass++;
        for (int j = 0; j < N_OUT; j++) begin
            n_checks++;
            if (d[j*WIDTH +: WIDTH] !== model(j)) $display("FAIL unity_lane%0d got %h exp %h", j, d[j*WIDTH +: WIDTH], model(j));
            else n_pass++;
        end
        n_checks++; if (d[1*WIDTH +: WIDTH] !== 24'h010000) $display("FAIL unity_half got %h exp 010000", d[1*WIDTH +: WIDTH]); else n_pass++;
        n_checks++;
        if (d[2*WIDTH +: WIDTH] !== (RELU ? 24'h000000 : 24'hFE0000)) $display("FAIL unity_neg got %h", d[2*WIDTH +: WIDTH]);
        else n_pass++;
        handshake();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL unity_hs_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL unity_hs_ready got %b exp 1", in_ready); else n_pass++;
        n_checks++; if (err_cnt != 0) $display("FAIL unity_frame_err got %0d exp 0", err_cnt); else n_pass++;
    endtask

    task automatic run_frame(input string tag, input bit gaps);
        logic [N_OUT*WIDTH-1:0] d; bit to; int lat;
        send_beats(0, N_IN, N_IN - 1, gaps);
        wait_out(d, to, lat);
        n_checks++; if (to) $display("FAIL %s_timeout got no out_valid exp out_valid", tag); else n_pass++;
        for (int j = 0; j < N_OUT; j++) begin
            n_checks++;
            if (d[j*WIDTH +: WIDTH] !== model(j)) $display("FAIL %s_lane%0d got %h exp %h", tag, j, d[j*WIDTH +: WIDTH], model(j));
            else n_pass++;
        end
        handshake();
    endtask

    task automatic test_bias_only();
        for (int i = 0; i < N_IN; i++) xs[i] = 0;
        run_frame("bias", 1'b1);
        n_checks++;
        if (out_data[0 +: WIDTH] !== (RELU ? 24'h000000 : 24'hFFFF01)) $display("FAIL bias_lane0 got %h", out_data[0 +: WIDTH]);
        else n_pass++;
        n_checks++; if (out_data[4*WIDTH +: WIDTH] !== 24'h000372) $display("FAIL bias_lane4 got %h exp 000372", out_data[4*WIDTH +: WIDTH]); else n_pass++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < N_IN; i++) xs[i] = 64'h7FFFFF;
        run_frame("sat_pos", 1'b0);
        n_checks++; if (out_data[4*WIDTH +: WIDTH] !== 24'h7FFFFF) $display("FAIL sat_pos_lane4 got %h exp 7fffff", out_data[4*WIDTH +: WIDTH]); else n_pass++;
        for (int i = 0; i < N_IN; i++) xs[i] = -(64'sh800000);
        run_frame("sat_neg", 1'b0);
        n_checks++;
        if (out_data[4*WIDTH +: WIDTH] !== (RELU ? 24'h000000 : 24'h800000)) $display("FAIL sat_neg_lane4 got %h", out_data[4*WIDTH +: WIDTH]);
        else n_pass++;
    endtask

    task automatic test_truncation();
        int p;
        p = $urandom_range(N_IN - 1);
        for (int i = 0; i < N_IN; i++) xs[i] = 0;
        xs[p] = 1;
        run_frame("trunc_pos", 1'b1);
        n_checks++; if (out_data[1*WIDTH +: WIDTH] !== 24'h000000) $display("FAIL trunc_pos_lane1 got %h exp 000000", out_data[1*WIDTH +: WIDTH]); else n_pass++;
        xs[p] = -1;
        run_frame("trunc_neg", 1'b1);
        n_checks++;
        if (out_data[1*WIDTH +: WIDTH] !== (RELU ? 24'h000000 : 24'hFFFFFF)) $display("FAIL trunc_neg_lane1 got %h", out_data[1*WIDTH +: WIDTH]);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N_IN; i++)
                xs[i] = (f % 2 == 0) ? longint'($urandom_range(262143)) - 131072
                                     : longint'($signed(WIDTH'($urandom)));
            run_frame("random", 1'b1);
        end
    endtask

    task automatic test_backpressure();
        logic [N_OUT*WIDTH-1:0] d; bit to; int lat; bit ok_v, ok_d, ok_r;
        for (int i = 0; i < N_IN; i++) xs[i] = longint'($urandom_range(65535)) - 32768;
        err_cnt = 0;
        send_beats(0, N_IN, N_IN - 1, 1'b0);
        wait_out(d, to, lat);
        n_checks++; if (to) $display("FAIL bp_timeout got no out_valid exp out_valid"); else n_pass++;
        ok_v = 1'b1; ok_d = 1'b1; ok_r = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_last = 1'b1; in_data = WIDTH'($urandom);
            @(posedge clk); #1;
            if (out_valid !== 1'b1) ok_v = 1'b0;
            if (out_data !== d) ok_d = 1'b0;
            if (in_ready !== 1'b0) ok_r = 1'b0;
        end
        n_checks++; if (!ok_v) $display("FAIL bp_valid_hold got drop exp held"); else n_pass++;
        n_checks++; if (!ok_d) $display("FAIL bp_data_hold got %h exp %h", out_data, d); else n_pass++;
        n_checks++; if (!ok_r) $display("FAIL bp_in_ready got %b exp 0", in_ready); else n_pass++;
        for (int j = 0; j < N_OUT; j++) begin
            n_checks++;
            if (d[j*WIDTH +: WIDTH] !== model(j)) $display("FAIL bp_lane%0d got %h exp %h", j, d[j*WIDTH +: WIDTH], model(j));
            else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", in_ready); else n_pass++;
        n_checks++; if (err_cnt != 0) $display("FAIL bp_frame_err got %0d exp 0", err_cnt); else n_pass++;
        for (int i = 0; i < N_IN; i++) xs[i] = longint'($urandom_range(65535)) - 32768;
        run_frame("bp_next", 1'b0);
    endtask

    task automatic test_frame_err();
        for (int i = 0; i < N_IN; i++) xs[i] = longint'($urandom_range(65535)) - 32768;
        err_cnt = 0;
        send_beats(0, 11, 10, 1'b0);
        n_checks++; if (frame_err !== 1'b1) $display("FAIL ferr_pulse got %b exp 1", frame_err); else n_pass++;
        send_beats(11, N_IN - 11, -1, 1'b1);
        begin
            logic [N_OUT*WIDTH-1:0] d; bit to; int lat;
            wait_out(d, to, lat);
            n_checks++; if (to || lat != 1) $display("FAIL ferr_complete got lat %0d timeout %0d exp 1", lat, to); else n_pass++;
            for (int j = 0; j < N_OUT; j++) begin
                n_checks++;
                if (d[j*WIDTH +: WIDTH] !== model(j)) $display("FAIL ferr_lane%0d got %h exp %h", j, d[j*WIDTH +: WIDTH], model(j));
                else n_pass++;
            end
            handshake();
        end
        n_checks++; if (err_cnt != 2) $display("FAIL ferr_count got %0d exp 2", err_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [N_OUT*WIDTH-1:0] d; bit to; int lat;
        for (int i = 0; i < N_IN; i++) xs[i] = longint'($urandom_range(65535)) - 32768;
        send_beats(0, 15, -1, 1'b0);
        rst = 1'b1; #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rstmid_ready got %b exp 0", in_ready); else n_pass++;
        @(posedge clk); #1; rst = 1'b0; @(posedge clk); #1;
        send_beats(0, N_IN, N_IN - 1, 1'b0);
        wait_out(d, to, lat);
        n_checks++; if (to) $display("FAIL rstout_timeout got no out_valid exp out_valid"); else n_pass++;
        rst = 1'b1; #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rstout_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL rstout_data got %h exp 0", out_data); else n_pass++;
        @(posedge clk); #1; rst = 1'b0; @(posedge clk); #1;
        for (int i = 0; i < N_IN; i++) xs[i] = longint'($signed(WIDTH'($urandom))) >>> 4;
        run_frame("rst_after", 1'b1);
    endtask

    initial begin
        test_reset();
        test_unity();
        test_bias_only();
        test_saturation();
        test_truncation();
        test_random();
        test_backpressure();
        test_frame_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
